// File: rtl/shifter_pkg.sv
// Shared encodings and defaults for the serial shifter slice.
package shifter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/mux2to1.sv
// One-bit 2:1 selector: m = s ? y : x.
module mux2to1 (
    input  logic x,
    input  logic y,
    input  logic s,
    output logic m
);

    assign m = s ? y : x;

endmodule

// File: rtl/serial_shifter.sv
// Parallel-load, LSB-first serial-out shift register with bit counter and
// IDLE/SHIFT/DONE control; outputs are decoded from registers only.
module serial_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             shift_en,
    input  logic             rotate,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d, shifted;
    logic             fill;
    logic             do_shift;

    mux2to1 u_fill (
        .x (serial_in),
        .y (q_q[0]),
        .s (rotate),
        .m (fill)
    );

    // Non-shifting cycles feed the current value back, so the load muxes
    // alone decide between hold, shift and parallel capture.
    always_comb begin
        do_shift = (state_q == SHIFT) && shift_en;
        shifted  = do_shift ? {fill, q_q[WIDTH-1:1]} : q_q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2to1 u_bit (
            .x (shifted[i]),
            .y (data[i]),
            .s (load),
            .m (q_d[i])
        );
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (load) begin
            state_d = SHIFT;
            count_d = '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (shift_en) begin
                        if (count_q == CW'(WIDTH - 1)) begin
                            state_d = DONE;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

    assign q          = q_q;
    assign serial_out = q_q[0];
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);

endmodule
